rv_alu_issue: RTL and testbench
===============================

# rv_alu_issue

Execute-stage issue/retire unit for the 64-bit RV core: the driving and consuming end of the combinational ALU. It accepts decoded instruction fields with a valid/ready handshake, decodes the ALU operation select, and registers operands into the ALU. It then captures the ALU result and zero flag, resolves BEQ/BNE and hands the result downstream. It is a two-stage pipeline (issue register S1, retire register S2) with full backpressure and flush.

## Interface
- XLEN, 64, operand/result width
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous; empties S1 and S2
- in_valid_i  in  1  input fields valid
- in_ready_o  out  1  unit can accept this cycle
- aluop_i  in  2  00 mem-addr, 01 branch, 10 arith/logic, 11 pass-op1
- funct3_i  in  3  instruction funct3
- funct7b5_i  in  1  instruction bit 30
- rtype_i  in  1  1 = R-type (enables SUB decode)
- alusrc_i  in  1  0 = op2 from rs2_i, 1 = op2 from imm_i
- rs1_i, rs2_i, imm_i  in  XLEN each  operand sources
- rd_i  in  5  destination register tag
- alu_op1_o, alu_op2_o  out  XLEN  registered ALU operands
- alu_op_sel_o  out  4  registered ALU select
- alu_result_i  in  XLEN  ALU result (combinational from alu_op*_o)
- alu_zero_i  in  1  ALU zero flag
- out_valid_o  out  1  S2 holds a result
- out_ready_i  in  1  downstream accepts
- out_result_o  out  XLEN  captured result
- out_rd_o  out  5  captured rd
- out_br_taken_o  out  1  branch taken (aluop 01 only)
- out_illegal_o  out  1  unsupported encoding flag

## Operation
- Decode (at input): aluop 00 -> 0010 (ADD); 01 -> 0110 (SUB); 11 -> 1111 (pass op1).
- aluop 10 decode: funct3 000 -> 0010, or 0110 if rtype_i & funct7b5_i; 111 -> 0000 (AND); 110 -> 0001 (OR); any other funct3 -> 1111 with illegal=1.
- aluop 01: funct3 000 = BEQ, 001 = BNE; other funct3 -> illegal=1, taken=0.
- op2 = alusrc_i ? imm_i : rs2_i; op1 = rs1_i.
- S1 holds valid, op1, op2, op_sel, rd, aluop, funct3 and the illegal flag, and drives alu_* directly.
- S2 capture: result = alu_result_i. taken = BEQ ? alu_zero_i : BNE ? ~alu_zero_i : 0. Illegal copied from S1.
- Advance rules: s2_free = ~s2_valid | out_ready_i. S1 moves to S2 when s1_valid & s2_free. in_ready_o = ~s1_valid | s2_free.
- Input is accepted on in_valid_i & in_ready_o and loads S1 the same edge S1 moves on, so back-to-back issue runs at 1/cycle.
- S2 clears on out_ready_i when no S1 entry moves in.
- Illegal ops still flow and retire with out_illegal_o=1; no stall.

## Timing
- Reset/flush: s1_valid=0, s2_valid=0. alu_op1_o, alu_op2_o and out_result_o = 0. alu_op_sel_o=1111. out_rd_o=0. out_br_taken_o=0. out_illegal_o=0. in_ready_o=1 in the cycle after reset/flush deasserts.
- Latency: accept at edge N -> alu_* valid after N -> out_valid_o after edge N+1 (2 edges input-to-output).
- Throughput: 1 op/cycle with out_ready_i held high.
- Full stall: S1 and S2 valid, out_ready_i=0 -> in_ready_o=0. All registers hold. alu_* stays stable so alu_result_i stays consistent.
- Simultaneous accept into S1, S1->S2 move and S2 drain in one edge is legal; no bubble.
- flush_i has priority over all handshakes. An input presented with flush_i is dropped.
- rst_i has priority over flush_i. Reset mid-operation discards everything.
- out_* stays stable while out_valid_o & ~out_ready_i.
- in_ready_o is combinational from state and out_ready_i only, never from in_valid_i.

## Structure
- Shared core package holds the op_sel constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_PASS=1111.
- The package also holds the aluop encodings and the BEQ/BNE funct3 values, shared with the ALU and the main decoder.
- Natural sub-module: rv_alu_ctrl, combinational {aluop, funct3, funct7b5, rtype} -> {op_sel, illegal}.
- Bench instantiates rv_alu_issue plus the existing ALU, looped through alu_* ports.

## Test plan
- R-type SUB: aluop=10, funct3=000, funct7b5=1, rtype=1, rs1=10, rs2=3 -> alu_op_sel_o=0110 after edge 1. Out result=7, illegal=0 after edge 2.
- I-type ADDI with funct7b5=1, rtype=0: rs1=5, imm=0xFFFF_FFFF_FFFF_FFFF, alusrc=1 -> op_sel=0010, result=4.
- Branches: BEQ rs1=rs2=0x55 -> taken=1, result=0. BNE with the same operands -> taken=0. BNE rs1=1, rs2=2 -> taken=1.
- Backpressure: 4 back-to-back ops with out_ready_i=0 -> in_ready_o drops after 2 accepts, outputs hold. Releasing out_ready_i retires all 4 in order, 1/cycle, no loss or duplication.
- Illegal: aluop=10, funct3=001 -> op_sel=1111, result=rs1, out_illegal_o=1. Illegal branch funct3=100 -> taken=0, illegal=1.
- flush_i asserted with both stages full and in_valid_i=1 -> next cycle out_valid_o=0 and in_ready_o=1. The flushed input never appears. Repeat the same with rst_i.

Source files
------------

// File: rtl/rv_alu_issue_pkg.sv
// Shared encodings for the execute stage: ALU select codes, ALU-op classes,
// the branch funct3 values and the pipeline register layouts.
package rv_alu_issue_pkg;

   localparam int XLEN = 64;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0110,
      ALU_PASS = 4'b1111
   } alu_sel_e;

   typedef enum logic [1:0] {
      ALUOP_MEM    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_ARITH  = 2'b10,
      ALUOP_PASS   = 2'b11
   } aluop_e;

   localparam logic [2:0] F3_BEQ    = 3'b000;
   localparam logic [2:0] F3_BNE    = 3'b001;
   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_AND    = 3'b111;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [3:0]      op_sel;
      logic [4:0]      rd;
      logic [1:0]      aluop;
      logic [2:0]      funct3;
      logic            illegal;
   } s1_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] result;
      logic [4:0]      rd;
      logic            taken;
      logic            illegal;
   } s2_t;

   localparam s1_t S1_RESET = '{valid: 1'b0, op1: '0, op2: '0, op_sel: ALU_PASS,
                                rd: '0, aluop: '0, funct3: '0, illegal: 1'b0};
   localparam s2_t S2_RESET = '{valid: 1'b0, result: '0, rd: '0, taken: 1'b0,
                                illegal: 1'b0};

endpackage

// File: rtl/rv_alu_issue_ctrl.sv
// ALU control decoder: maps {aluop, funct3, funct7b5, rtype} to an ALU
// select code and flags encodings this ALU does not implement.
module rv_alu_ctrl
   import rv_alu_issue_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       rtype_i,
   output logic [3:0] op_sel_o,
   output logic       illegal_o
);

   always_comb begin
      op_sel_o  = ALU_PASS;
      illegal_o = 1'b0;
      case (aluop_i)
         ALUOP_MEM:    op_sel_o = ALU_ADD;
         ALUOP_BRANCH: begin
            op_sel_o  = ALU_SUB;
            illegal_o = (funct3_i != F3_BEQ) && (funct3_i != F3_BNE);
         end
         ALUOP_ARITH: begin
            case (funct3_i)
               // funct7b5 only means SUB on R-type; on ADDI it is immediate bits
               F3_ADDSUB: op_sel_o = (rtype_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
               F3_AND:    op_sel_o = ALU_AND;
               F3_OR:     op_sel_o = ALU_OR;
               default: begin
                  op_sel_o  = ALU_PASS;
                  illegal_o = 1'b1;
               end
            endcase
         end
         default:      op_sel_o = ALU_PASS;
      endcase
   end

endmodule

// File: rtl/rv_alu_issue.sv
// Execute-stage issue/retire unit: S1 registers decoded operands into the
// combinational ALU, S2 captures its result and resolves BEQ/BNE.
module rv_alu_issue
   import rv_alu_issue_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [1:0]      aluop_i,
   input  logic [2:0]      funct3_i,
   input  logic            funct7b5_i,
   input  logic            rtype_i,
   input  logic            alusrc_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [4:0]      rd_i,
   output logic [XLEN-1:0] alu_op1_o,
   output logic [XLEN-1:0] alu_op2_o,
   output logic [3:0]      alu_op_sel_o,
   input  logic [XLEN-1:0] alu_result_i,
   input  logic            alu_zero_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] out_result_o,
   output logic [4:0]      out_rd_o,
   output logic            out_br_taken_o,
   output logic            out_illegal_o
);

   s1_t        s1_q, s1_d;
   s2_t        s2_q, s2_d;
   logic [3:0] dec_sel;
   logic       dec_illegal;
   logic       s2_free;
   logic       s1_move;
   logic       in_fire;
   logic       br_taken;

   rv_alu_ctrl u_ctrl (
      .aluop_i    (aluop_i),
      .funct3_i   (funct3_i),
      .funct7b5_i (funct7b5_i),
      .rtype_i    (rtype_i),
      .op_sel_o   (dec_sel),
      .illegal_o  (dec_illegal)
   );

   assign s2_free    = ~s2_q.valid | out_ready_i;
   assign s1_move    = s1_q.valid & s2_free;
   assign in_ready_o = ~s1_q.valid | s2_free;
   assign in_fire    = in_valid_i & in_ready_o;

   assign br_taken = (s1_q.aluop == ALUOP_BRANCH) &
                     (((s1_q.funct3 == F3_BEQ) &  alu_zero_i) |
                      ((s1_q.funct3 == F3_BNE) & ~alu_zero_i));

   // A stage that empties keeps its payload so the ALU inputs and out_* stay quiet.
   always_comb begin
      s1_d = s1_q;
      if (flush_i) begin
         s1_d = S1_RESET;
      end else if (in_fire) begin
         s1_d.valid   = 1'b1;
         s1_d.op1     = rs1_i;
         s1_d.op2     = alusrc_i ? imm_i : rs2_i;
         s1_d.op_sel  = dec_sel;
         s1_d.rd      = rd_i;
         s1_d.aluop   = aluop_i;
         s1_d.funct3  = funct3_i;
         s1_d.illegal = dec_illegal;
      end else if (s1_move) begin
         s1_d.valid = 1'b0;
      end
   end

   always_comb begin
      s2_d = s2_q;
      if (flush_i) begin
         s2_d = S2_RESET;
      end else if (s1_move) begin
         s2_d.valid   = 1'b1;
         s2_d.result  = alu_result_i;
         s2_d.rd      = s1_q.rd;
         s2_d.taken   = br_taken;
         s2_d.illegal = s1_q.illegal;
      end else if (out_ready_i) begin
         s2_d.valid = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= S1_RESET;
         s2_q <= S2_RESET;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign alu_op1_o      = s1_q.op1;
   assign alu_op2_o      = s1_q.op2;
   assign alu_op_sel_o   = s1_q.op_sel;
   assign out_valid_o    = s2_q.valid;
   assign out_result_o   = s2_q.result;
   assign out_rd_o       = s2_q.rd;
   assign out_br_taken_o = s2_q.taken;
   assign out_illegal_o  = s2_q.illegal;

endmodule

// File: tb/tb_rv_alu_issue.sv
// Directed self-checking bench for rv_alu_issue with a behavioural ALU
// closing the loop between alu_* outputs and alu_result_i/alu_zero_i.
module tb_rv_alu_issue;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [1:0]  aluop_i = '0;
   logic [2:0]  funct3_i = '0;
   logic        funct7b5_i = 1'b0;
   logic        rtype_i = 1'b0;
   logic        alusrc_i = 1'b0;
   logic [63:0] rs1_i = '0;
   logic [63:0] rs2_i = '0;
   logic [63:0] imm_i = '0;
   logic [4:0]  rd_i = '0;
   logic [63:0] alu_op1_o;
   logic [63:0] alu_op2_o;
   logic [3:0]  alu_op_sel_o;
   logic [63:0] alu_result_i;
   logic        alu_zero_i;
   logic        out_valid_o;
   logic        out_ready_i = 1'b1;
   logic [63:0] out_result_o;
   logic [4:0]  out_rd_o;
   logic        out_br_taken_o;
   logic        out_illegal_o;

   int checks = 0;
   int failures = 0;

   rv_alu_issue dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .flush_i        (flush_i),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .aluop_i        (aluop_i),
      .funct3_i       (funct3_i),
      .funct7b5_i     (funct7b5_i),
      .rtype_i        (rtype_i),
      .alusrc_i       (alusrc_i),
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .imm_i          (imm_i),
      .rd_i           (rd_i),
      .alu_op1_o      (alu_op1_o),
      .alu_op2_o      (alu_op2_o),
      .alu_op_sel_o   (alu_op_sel_o),
      .alu_result_i   (alu_result_i),
      .alu_zero_i     (alu_zero_i),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_result_o   (out_result_o),
      .out_rd_o       (out_rd_o),
      .out_br_taken_o (out_br_taken_o),
      .out_illegal_o  (out_illegal_o)
   );

   always #5 clk_i = ~clk_i;

   // Stand-in for the core's ALU
   always_comb begin
      case (alu_op_sel_o)
         4'b0000: alu_result_i = alu_op1_o & alu_op2_o;
         4'b0001: alu_result_i = alu_op1_o | alu_op2_o;
         4'b0010: alu_result_i = alu_op1_o + alu_op2_o;
         4'b0110: alu_result_i = alu_op1_o - alu_op2_o;
         default: alu_result_i = alu_op1_o;
      endcase
   end
   assign alu_zero_i = (alu_result_i == 64'd0);

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] aluop, input logic [2:0] f3,
                                input logic f7b5, input logic rtype, input logic alusrc,
                                input logic [63:0] rs1, input logic [63:0] rs2,
                                input logic [63:0] imm, input logic [4:0] rd);
      in_valid_i = 1'b1;
      aluop_i    = aluop;
      funct3_i   = f3;
      funct7b5_i = f7b5;
      rtype_i    = rtype;
      alusrc_i   = alusrc;
      rs1_i      = rs1;
      rs2_i      = rs2;
      imm_i      = imm;
      rd_i       = rd;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      #1;
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid actual=%b required=0", out_valid_o); end
      checks++; if (in_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready actual=%b required=1", in_ready_o); end
      checks++; if (alu_op_sel_o !== 4'b1111) begin failures++; $display("[TB] FAIL reset_op_sel actual=%b required=1111", alu_op_sel_o); end
      checks++; if (alu_op1_o !== 64'd0 || alu_op2_o !== 64'd0) begin failures++; $display("[TB] FAIL reset_operands actual=%h/%h required=0/0", alu_op1_o, alu_op2_o); end
      checks++; if (out_result_o !== 64'd0 || out_rd_o !== 5'd0) begin failures++; $display("[TB] FAIL reset_result actual=%h rd=%0d required=0 rd=0", out_result_o, out_rd_o); end
      checks++; if (out_br_taken_o !== 1'b0 || out_illegal_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags actual=%b%b required=00", out_br_taken_o, out_illegal_o); end
   endtask

   task automatic test_sub();
      out_ready_i = 1'b1;
      applyStimulus(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 64'd10, 64'd3, 64'd0, 5'd7);
      tick();
      in_valid_i = 1'b0;
      checks++; if (alu_op_sel_o !== 4'b0110) begin failures++; $display("[TB] FAIL sub_op_sel actual=%b required=0110", alu_op_sel_o); end
      checks++; if (alu_op1_o !== 64'd10 || alu_op2_o !== 64'd3) begin failures++; $display("[TB] FAIL sub_operands actual=%0d/%0d required=10/3", alu_op1_o, alu_op2_o); end
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL sub_early_valid actual=%b required=0", out_valid_o); end
      tick();
      checks++; if (out_valid_o !== 1'b1 || out_result_o !== 64'd7 || out_rd_o !== 5'd7) begin failures++; $display("[TB] FAIL sub_result actual=v%b %0d rd%0d required=v1 7 rd7", out_valid_o, out_result_o, out_rd_o); end
      checks++; if (out_illegal_o !== 1'b0) begin failures++; $display("[TB] FAIL sub_illegal actual=%b required=0", out_illegal_o); end
      tick();
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL sub_drain actual=%b required=0", out_valid_o); end
   endtask

   task automatic test_addi();
      applyStimulus(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 64'd5, 64'd99, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3);
      tick();
      in_valid_i = 1'b0;
      checks++; if (alu_op_sel_o !== 4'b0010) begin failures++; $display("[TB] FAIL addi_op_sel actual=%b required=0010", alu_op_sel_o); end
      tick();
      checks++; if (out_valid_o !== 1'b1 || out_result_o !== 64'd4) begin failures++; $display("[TB] FAIL addi_result actual=v%b %h required=v1 4", out_valid_o, out_result_o); end
      tick();
   endtask

   task automatic test_branch();
      logic [2:0]  f3_tab  [3] = '{3'b000, 3'b001, 3'b001};
      logic [63:0] rs1_tab [3] = '{64'h55, 64'h55, 64'd1};
      logic [63:0] rs2_tab [3] = '{64'h55, 64'h55, 64'd2};
      logic        tk_tab  [3] = '{1'b1, 1'b0, 1'b1};
      logic [63:0] res_tab [3] = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(2'b01, f3_tab[i], 1'b0, 1'b0, 1'b0, rs1_tab[i], rs2_tab[i], 64'd0, 5'd9);
         tick();
         in_valid_i = 1'b0;
         tick();
         checks++; if (out_valid_o !== 1'b1 || out_br_taken_o !== tk_tab[i]) begin failures++; $display("[TB] FAIL branch%0d_taken actual=v%b t%b required=v1 t%b", i, out_valid_o, out_br_taken_o, tk_tab[i]); end
         checks++; if (out_result_o !== res_tab[i] || out_illegal_o !== 1'b0) begin failures++; $display("[TB] FAIL branch%0d_result actual=%h ill%b required=%h ill0", i, out_result_o, out_illegal_o, res_tab[i]); end
         tick();
      end
   endtask

   task automatic test_illegal();
      applyStimulus(2'b10, 3'b001, 1'b0, 1'b1, 1'b0, 64'h1234, 64'd7, 64'd0, 5'd11);
      tick();
      in_valid_i = 1'b0;
      checks++; if (alu_op_sel_o !== 4'b1111) begin failures++; $display("[TB] FAIL illegal_op_sel actual=%b required=1111", alu_op_sel_o); end
      tick();
      checks++; if (out_valid_o !== 1'b1 || out_result_o !== 64'h1234 || out_illegal_o !== 1'b1) begin failures++; $display("[TB] FAIL illegal_arith actual=v%b %h ill%b required=v1 1234 ill1", out_valid_o, out_result_o, out_illegal_o); end
      tick();
      applyStimulus(2'b01, 3'b100, 1'b0, 1'b0, 1'b0, 64'd5, 64'd5, 64'd0, 5'd12);
      tick();
      in_valid_i = 1'b0;
      tick();
      checks++; if (out_valid_o !== 1'b1 || out_br_taken_o !== 1'b0 || out_illegal_o !== 1'b1) begin failures++; $display("[TB] FAIL illegal_branch actual=v%b t%b ill%b required=v1 t0 ill1", out_valid_o, out_br_taken_o, out_illegal_o); end
      tick();
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int retired = 0;
      int first_ret = -1;
      int last_ret = -1;
      bit acc;
      bit ret;
      out_ready_i = 1'b0;
      for (int cyc = 0; cyc < 40 && retired < 4; cyc++) begin
         if (cyc == 6) out_ready_i = 1'b1;
         if (sent < 4)
            applyStimulus(2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 64'(100 + sent), 64'(sent), 64'd0, 5'(sent + 1));
         else
            in_valid_i = 1'b0;
         #1;
         acc = in_valid_i && in_ready_o;
         ret = out_valid_o && out_ready_i;
         if (cyc == 4) begin
            checks++; if (in_ready_o !== 1'b0 || sent != 2) begin failures++; $display("[TB] FAIL b2b_stall actual=rdy%b sent%0d required=rdy0 sent2", in_ready_o, sent); end
         end
         if (cyc >= 2 && cyc <= 5) begin
            checks++; if (out_rd_o !== 5'd1 || out_result_o !== 64'd100 || alu_op1_o !== 64'd101) begin failures++; $display("[TB] FAIL b2b_hold actual=rd%0d %0d op1=%0d required=rd1 100 op1=101", out_rd_o, out_result_o, alu_op1_o); end
         end
         if (ret) begin
            checks++; if (out_rd_o !== 5'(retired + 1) || out_result_o !== 64'(100 + 2 * retired)) begin failures++; $display("[TB] FAIL b2b_order actual=rd%0d %0d required=rd%0d %0d", out_rd_o, out_result_o, retired + 1, 100 + 2 * retired); end
            if (first_ret < 0) first_ret = cyc;
            last_ret = cyc;
            retired++;
         end
         if (acc) sent++;
         tick();
      end
      in_valid_i = 1'b0;
      checks++; if (retired != 4 || sent != 4) begin failures++; $display("[TB] FAIL b2b_count actual=sent%0d ret%0d required=4/4", sent, retired); end
      checks++; if (last_ret - first_ret != 3) begin failures++; $display("[TB] FAIL b2b_rate actual=%0d cycles required=3", last_ret - first_ret); end
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_empty actual=%b required=0", out_valid_o); end
   endtask

   task automatic test_flush_or_reset(input bit use_rst);
      int seen = 0;
      out_ready_i = 1'b0;
      applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 64'd1, 64'd1, 64'd0, 5'd21);
      tick();
      applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 64'd2, 64'd2, 64'd0, 5'd22);
      tick();
      checks++; if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL kill%0d_full actual=rdy%b v%b required=rdy0 v1", use_rst, in_ready_o, out_valid_o); end
      applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 64'd3, 64'd3, 64'd0, 5'd23);
      if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
      tick();
      rst_i = 1'b0;
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      #1;
      checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL kill%0d_empty actual=v%b rdy%b required=v0 rdy1", use_rst, out_valid_o, in_ready_o); end
      checks++; if (alu_op_sel_o !== 4'b1111 || alu_op1_o !== 64'd0 || out_result_o !== 64'd0 || out_rd_o !== 5'd0) begin failures++; $display("[TB] FAIL kill%0d_values actual=sel%b op1=%h res=%h rd%0d required=sel1111 0 0 rd0", use_rst, alu_op_sel_o, alu_op1_o, out_result_o, out_rd_o); end
      out_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (out_valid_o === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("[TB] FAIL kill%0d_ghost actual=%0d outputs required=0", use_rst, seen); end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_sub();
      test_addi();
      test_branch();
      test_illegal();
      test_back_to_back();
      test_flush_or_reset(1'b0);
      test_flush_or_reset(1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
